executor_dispatch: RTL and testbench

- Sequencer that owns the four tile executors: move-left, move-right, rotate and move-down.
- Buffers player commands in a small FIFO and merges them with the gravity tick. Gravity has priority.
- Issues exactly one executor at a time with a one-cycle valid pulse, then waits for that executor's done before issuing the next command.
- Sits between the keyboard decoder / gravity timer and the executor bank. A watchdog aborts hung executors.

---
 rtl/executor_dispatch.sv | 127 ++++++++++++
 tb/tb_executor_dispatch.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/executor_dispatch.sv
// Sequencer for the four tile executors: queues player commands, merges the
// gravity tick (gravity first) and issues one executor at a time with a watchdog.
module executor_dispatch #(
  parameter int fifo_depth_p = 4,
  parameter int timeout_p    = 255
) (
  input  logic                               clk_i,
  input  logic                               reset_i,
  input  logic                               enable_i,
  input  logic                               flush_i,
  input  logic                               cmd_v_i,
  input  logic [1:0]                         cmd_i,
  output logic                               cmd_ready_o,
  input  logic                               gravity_tick_i,
  output logic [3:0]                         exec_v_o,
  input  logic [3:0]                         exec_done_i,
  output logic                               busy_o,
  output logic [$clog2(fifo_depth_p+1)-1:0]  fifo_count_o,
  output logic                               overrun_o,
  output logic                               timeout_o
);

  localparam int cnt_w_lp = $clog2(fifo_depth_p + 1);
  localparam int ptr_w_lp = $clog2(fifo_depth_p);
  localparam int wd_w_lp  = $clog2(timeout_p + 1);

  typedef enum logic [1:0] {eIDLE, eIssue, eWait} state_e;

  state_e               state_r, state_n;
  logic [1:0]           mem_r [fifo_depth_p];
  logic [ptr_w_lp-1:0]  wr_ptr_r, rd_ptr_r;
  logic [cnt_w_lp-1:0]  count_r;
  logic                 grav_pend_r, overrun_r, timeout_r;
  logic [1:0]           sel_r;
  logic [wd_w_lp-1:0]   wd_r, wd_inc;

  logic fifo_empty, push, launch, take_grav, pop, sel_done, wd_hit;

  assign fifo_empty  = (count_r == '0);
  assign cmd_ready_o = (count_r != cnt_w_lp'(fifo_depth_p));
  assign push        = cmd_v_i & cmd_ready_o & ~flush_i;
  assign launch      = (state_r == eIDLE) & enable_i & ~flush_i;
  assign take_grav   = launch & grav_pend_r;
  assign pop         = launch & ~grav_pend_r & ~fifo_empty;
  assign sel_done    = exec_done_i[sel_r];
  // Watchdog saturates at the compare value so it can never wrap past it.
  assign wd_inc      = (wd_r == wd_w_lp'(timeout_p)) ? wd_r : wd_r + 1'b1;
  assign wd_hit      = (wd_inc == wd_w_lp'(timeout_p));

  assign fifo_count_o = count_r;
  assign overrun_o    = overrun_r;
  assign timeout_o    = timeout_r;

  // Command storage carries data only, so it has no reset.
  always_ff @(posedge clk_i) begin
    if (push) mem_r[wr_ptr_r] <= cmd_i;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else if (flush_i) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push) wr_ptr_r <= wr_ptr_r + 1'b1;
      if (pop)  rd_ptr_r <= rd_ptr_r + 1'b1;
      case ({push, pop})
        2'b10:   count_r <= count_r + 1'b1;
        2'b01:   count_r <= count_r - 1'b1;
        default: count_r <= count_r;
      endcase
    end
  end

  // A tick coinciding with consumption re-arms pending rather than counting as overrun.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      grav_pend_r <= 1'b0;
      overrun_r   <= 1'b0;
    end else begin
      if (flush_i)             grav_pend_r <= 1'b0;
      else if (gravity_tick_i) grav_pend_r <= 1'b1;
      else if (take_grav)      grav_pend_r <= 1'b0;
      if (gravity_tick_i & grav_pend_r & ~take_grav & ~flush_i) overrun_r <= 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      sel_r     <= 2'd0;
      wd_r      <= '0;
      timeout_r <= 1'b0;
    end else begin
      if (take_grav) sel_r <= 2'd3;
      else if (pop)  sel_r <= mem_r[rd_ptr_r];
      if (state_r == eIssue)     wd_r <= '0;
      else if (state_r == eWait) wd_r <= wd_inc;
      if ((state_r == eWait) & ~sel_done & wd_hit) timeout_r <= 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) state_r <= eIDLE;
    else         state_r <= state_n;
  end

  always_comb begin
    state_n = state_r;
    case (state_r)
      eIDLE:   if (take_grav | pop) state_n = eIssue;
      eIssue:  state_n = sel_done ? eIDLE : eWait;
      eWait:   if (sel_done | wd_hit) state_n = eIDLE;
      default: state_n = eIDLE;
    endcase
  end

  always_comb begin
    exec_v_o = 4'b0000;
    busy_o   = (state_r != eIDLE);
    if (state_r == eIssue) exec_v_o = 4'b0001 << sel_r;
  end

endmodule

// File: tb/tb_executor_dispatch.sv
// Directed bench for executor_dispatch (fifo depth 4, watchdog limit 8).
module tb_executor_dispatch;

  logic       clk_i = 1'b0;
  logic       reset_i, enable_i, flush_i, cmd_v_i, gravity_tick_i;
  logic [1:0] cmd_i;
  logic       cmd_ready_o, busy_o, overrun_o, timeout_o;
  logic [3:0] exec_v_o, exec_done_i, done_manual;
  logic [2:0] fifo_count_o;
  logic       auto_done;

  int checks   = 0;
  int failures = 0;

  always #5 clk_i = ~clk_i;

  // Executor model: either acknowledges in the issue cycle or follows done_manual.
  assign exec_done_i = auto_done ? exec_v_o : done_manual;

  executor_dispatch #(.fifo_depth_p(4), .timeout_p(8)) dut (
    .clk_i          (clk_i),
    .reset_i        (reset_i),
    .enable_i       (enable_i),
    .flush_i        (flush_i),
    .cmd_v_i        (cmd_v_i),
    .cmd_i          (cmd_i),
    .cmd_ready_o    (cmd_ready_o),
    .gravity_tick_i (gravity_tick_i),
    .exec_v_o       (exec_v_o),
    .exec_done_i    (exec_done_i),
    .busy_o         (busy_o),
    .fifo_count_o   (fifo_count_o),
    .overrun_o      (overrun_o),
    .timeout_o      (timeout_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  logic [1:0] codes [5];
  logic [3:0] order [4];

  initial begin
    codes = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    order = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
    reset_i = 1'b1; enable_i = 1'b1; flush_i = 1'b0; cmd_v_i = 1'b0; cmd_i = 2'd0;
    gravity_tick_i = 1'b0; done_manual = 4'b0000; auto_done = 1'b0;
    #3;
    check("rst_exec_v", exec_v_o, 4'b0000);
    check("rst_busy", busy_o, 0);
    check("rst_count", fifo_count_o, 0);
    check("rst_ready", cmd_ready_o, 1);
    check("rst_overrun", overrun_o, 0);
    check("rst_timeout", timeout_o, 0);
    @(posedge clk_i); #1;
    reset_i = 1'b0;

    // Single rotate, done three cycles after issue
    cmd_v_i = 1'b1; cmd_i = 2'd2; step(1); cmd_v_i = 1'b0;
    check("t1_count", fifo_count_o, 1);
    step(1);
    check("t1_issue", exec_v_o, 4'b0100);
    check("t1_busy0", busy_o, 1);
    check("t1_count0", fifo_count_o, 0);
    step(1);
    check("t1_wait_v", exec_v_o, 4'b0000);
    check("t1_busy1", busy_o, 1);
    step(1);
    check("t1_busy2", busy_o, 1);
    step(1);
    done_manual = 4'b0100;
    check("t1_busy3", busy_o, 1);
    step(1);
    done_manual = 4'b0000;
    check("t1_idle", busy_o, 0);

    // Three queued commands acknowledged in the issue cycle
    auto_done = 1'b1; enable_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cmd_v_i = 1'b1; cmd_i = 2'(i); step(1);
      check("t2_fill", fifo_count_o, i + 1);
    end
    cmd_v_i = 1'b0; enable_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1);
      check("t2_issue", exec_v_o, 4'b0001 << i);
      check("t2_drain", fifo_count_o, 2 - i);
      step(1);
      check("t2_gap", exec_v_o, 4'b0000);
    end
    check("t2_idle", busy_o, 0);

    // Overfill while an executor is held busy
    auto_done = 1'b0;
    cmd_v_i = 1'b1; cmd_i = 2'd0; step(1); cmd_v_i = 1'b0;
    step(1);
    check("t3_issue", exec_v_o, 4'b0001);
    for (int i = 0; i < 5; i++) begin
      cmd_v_i = 1'b1; cmd_i = codes[i]; step(1);
      check("t3_count", fifo_count_o, (i + 1 < 4) ? i + 1 : 4);
      check("t3_ready", cmd_ready_o, (i + 1 < 4) ? 1 : 0);
    end
    cmd_v_i = 1'b0;
    done_manual = 4'b0001; step(1);
    done_manual = 4'b0000; auto_done = 1'b1;
    check("t3_back_idle", busy_o, 0);
    for (int i = 0; i < 4; i++) begin
      step(1);
      check("t3_issue_n", exec_v_o, order[i]);
      step(1);
    end
    check("t3_empty", fifo_count_o, 0);
    check("t3_busy", busy_o, 0);
    step(1);
    check("t3_no_fifth", exec_v_o, 4'b0000);

    // Gravity versus queued left
    enable_i = 1'b0;
    cmd_v_i = 1'b1; cmd_i = 2'd0; gravity_tick_i = 1'b1; step(1);
    cmd_v_i = 1'b0; gravity_tick_i = 1'b0; enable_i = 1'b1;
    step(1);
    check("t4_down_first", exec_v_o, 4'b1000);
    step(2);
    check("t4_left_next", exec_v_o, 4'b0001);
    step(1);
    check("t4_no_overrun", overrun_o, 0);
    // Two ticks in one busy window
    auto_done = 1'b0;
    cmd_v_i = 1'b1; cmd_i = 2'd1; step(1); cmd_v_i = 1'b0;
    step(1);
    check("t4_right", exec_v_o, 4'b0010);
    gravity_tick_i = 1'b1; step(1);
    gravity_tick_i = 1'b0; step(1);
    gravity_tick_i = 1'b1; step(1);
    gravity_tick_i = 1'b0;
    check("t4_overrun", overrun_o, 1);
    done_manual = 4'b0010; step(1);
    done_manual = 4'b0000; auto_done = 1'b1;
    step(1);
    check("t4_one_down", exec_v_o, 4'b1000);
    step(2);
    check("t4_no_second", exec_v_o, 4'b0000);
    check("t4_idle", busy_o, 0);

    // Watchdog abort of a hung move-down
    auto_done = 1'b0; enable_i = 1'b0;
    cmd_v_i = 1'b1; cmd_i = 2'd3; step(1);
    cmd_i = 2'd0; step(1);
    cmd_v_i = 1'b0; enable_i = 1'b1;
    step(1);
    check("t5_issue", exec_v_o, 4'b1000);
    step(1);
    for (int k = 1; k <= 8; k++) begin
      check("t5_waiting", busy_o, 1);
      if (k == 8) check("t5_not_yet", timeout_o, 0);
      step(1);
    end
    check("t5_aborted", busy_o, 0);
    check("t5_timeout", timeout_o, 1);
    auto_done = 1'b1;
    step(1);
    check("t5_next", exec_v_o, 4'b0001);
    step(1);

    // Flush with queued entries and pending gravity
    enable_i = 1'b0;
    cmd_v_i = 1'b1; cmd_i = 2'd0; gravity_tick_i = 1'b1; step(1);
    gravity_tick_i = 1'b0; cmd_i = 2'd1; step(1);
    cmd_i = 2'd2; step(1);
    cmd_v_i = 1'b0;
    check("t6_full3", fifo_count_o, 3);
    flush_i = 1'b1; step(1); flush_i = 1'b0;
    check("t6_flushed", fifo_count_o, 0);
    enable_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step(1);
      check("t6_no_issue", exec_v_o, 4'b0000);
      check("t6_no_busy", busy_o, 0);
    end
    check("t6_overrun_kept", overrun_o, 1);
    check("t6_timeout_kept", timeout_o, 1);

    // Asynchronous reset mid-wait
    auto_done = 1'b0; enable_i = 1'b0;
    cmd_v_i = 1'b1; cmd_i = 2'd2; step(1);
    cmd_i = 2'd1; step(1);
    cmd_v_i = 1'b0; enable_i = 1'b1;
    step(1);
    check("t7_issue", exec_v_o, 4'b0100);
    step(1);
    check("t7_wait", busy_o, 1);
    #2 reset_i = 1'b1;
    #1;
    check("t7_exec_v", exec_v_o, 4'b0000);
    check("t7_busy", busy_o, 0);
    check("t7_count", fifo_count_o, 0);
    check("t7_ready", cmd_ready_o, 1);
    check("t7_timeout", timeout_o, 0);
    #2 reset_i = 1'b0;
    step(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
